spi_master_multi: RTL

Parametrised SPI master, successor to the fixed 8-bit single-slave controller. It adds:
- configurable frame width (1..DATA_W bits per transfer)
- NUM_CS one-hot chip selects
- a runtime SCLK divider
- MSB/LSB-first ordering
- all four CPOL/CPHA modes, selected per transfer

Sits between a register/DMA front end (start/ready/done handshake) and the off-chip SPI pins.

---
 rtl/spi_master_multi.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/spi_master_multi.sv
// spi_master_multi: SPI master with runtime frame width, one-hot chip selects,
// SCLK divider, bit ordering and all four CPOL/CPHA modes.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | ready, cs_n deasserted, sclk follows live cpol
//   ST_SETUP | cs_n asserted, first bit on mosi (cpha=0), waits one HP
//   ST_SHIFT | sclk toggles every HP; sample/drive on alternate edges
//   ST_HOLD  | sclk at rest, cs_n held one HP, then done pulse
module spi_master_multi #(
  parameter int DATA_W = 16,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8,
  parameter int LEN_W  = 5,
  localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ready,
  output logic              done,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [CS_W-1:0]   cs_sel,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [DIV_W:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [LEN_W:0]    edge_q, edge_d;
  logic [LEN_W-1:0]  n_q, n_d;
  logic              cpha_q, cpha_d;
  logic              lsb_q, lsb_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic              done_q, done_d;

  logic [LEN_W-1:0]  n_eff;
  logic [LEN_W:0]    tx_sh_amt;
  logic [DATA_W-1:0] tx_al;
  logic [LEN_W:0]    rx_sh_amt;
  logic [DATA_W-1:0] rx_al;
  logic [LEN_W:0]    edge_nxt;
  logic              evt;
  logic              is_sample;
  logic              last_edge;

  // Frame length resolution and bit alignment of tx (left-justified for MSB-first)
  // and rx (right-justified for LSB-first, which fills from the top).
  always_comb begin
    n_eff = frame_len;
    if (frame_len == '0 || frame_len > LEN_W'(DATA_W)) n_eff = LEN_W'(DATA_W);
    tx_sh_amt = (LEN_W+1)'(DATA_W) - {1'b0, n_eff};
    tx_al     = lsb_first ? tx_data : (tx_data << tx_sh_amt);
    rx_sh_amt = (LEN_W+1)'(DATA_W) - {1'b0, n_q};
    rx_al     = lsb_q ? (rx_sh_q >> rx_sh_amt) : rx_sh_q;
    edge_nxt  = edge_q + (LEN_W+1)'(1);
    evt       = (cnt_q == '0);
    is_sample = edge_nxt[0] ^ cpha_q;
    last_edge = (edge_nxt == {n_q, 1'b0});
  end

  // Next-state logic: the counter is loaded with HP at accept so that the first
  // SCLK edge lands HP+1 cycles after the accept edge, then reloads HP-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    edge_d  = edge_q;
    n_d     = n_q;
    cpha_d  = cpha_q;
    lsb_d   = lsb_q;
    tx_sh_d = tx_sh_q;
    rx_sh_d = rx_sh_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    rx_d    = rx_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sclk_d = cpol;
        mosi_d = 1'b0;
        cs_n_d = '1;
        if (start) begin
          state_d = ST_SETUP;
          n_d     = n_eff;
          div_d   = clk_div;
          cnt_d   = {1'b0, clk_div} + (DIV_W+1)'(1);
          edge_d  = '0;
          cpha_d  = cpha;
          lsb_d   = lsb_first;
          rx_sh_d = '0;
          for (int i = 0; i < NUM_CS; i++) begin
            if (cs_sel == CS_W'(i)) cs_n_d[i] = 1'b0;
          end
          if (!cpha) begin
            mosi_d  = lsb_first ? tx_al[0] : tx_al[DATA_W-1];
            tx_sh_d = lsb_first ? (tx_al >> 1) : (tx_al << 1);
          end else begin
            tx_sh_d = tx_al;
          end
        end
      end
      ST_SETUP, ST_SHIFT: begin
        cnt_d = evt ? {1'b0, div_q} : cnt_q - (DIV_W+1)'(1);
        if (evt) begin
          sclk_d  = ~sclk_q;
          edge_d  = edge_nxt;
          state_d = last_edge ? ST_HOLD : ST_SHIFT;
          if (is_sample) begin
            rx_sh_d = lsb_q ? {miso, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], miso};
          end else if (!last_edge) begin
            mosi_d  = lsb_q ? tx_sh_q[0] : tx_sh_q[DATA_W-1];
            tx_sh_d = lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
          end
        end
      end
      ST_HOLD: begin
        cnt_d = evt ? {1'b0, div_q} : cnt_q - (DIV_W+1)'(1);
        if (evt) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          rx_d    = rx_al;
          cs_n_d  = '1;
          mosi_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      edge_q  <= '0;
      n_q     <= '0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= '1;
      rx_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      n_q     <= n_d;
      cpha_q  <= cpha_d;
      lsb_q   <= lsb_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      rx_q    <= rx_d;
      done_q  <= done_d;
    end
  end

  assign ready   = (state_q == ST_IDLE);
  assign done    = done_q;
  assign rx_data = rx_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;

endmodule
